alu_control_md: RTL

Second-generation ALU control for the MIPS core. It decodes aluop/funct into a 4-bit ALU opcode that covers the extended R-type set: shifts, XOR, NOR, SLTU and ORI. It also owns an iterative multiply/divide sequencer with HI/LO registers for MULT/MULTU/DIV/DIVU. It sits in EX beside the ALU and raises a stall to the hazard unit while a HI/LO consumer or a second mul/div op would collide with a busy operation.

---
 rtl/alu_control_md.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_control_md.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_md
// Brief    : ALU control decoder with an iterative multiply/divide sequencer
//            that owns the HI/LO registers and stalls colliding consumers.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucont,
    output logic             invalid,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    localparam logic [5:0] C_F_MULT  = 6'b011000;
    localparam logic [5:0] C_F_MULTU = 6'b011001;
    localparam logic [5:0] C_F_DIV   = 6'b011010;
    localparam logic [5:0] C_F_DIVU  = 6'b011011;
    localparam logic [5:0] C_F_MFHI  = 6'b010000;
    localparam logic [5:0] C_F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     op_q, op_d;       // multiplicand or divisor magnitude
    logic                 sa_q, sa_d;       // sign of srca (0 for unsigned ops)
    logic                 sb_q, sb_d;       // sign of srcb (0 for unsigned ops)
    logic                 is_mul_q, is_mul_d;
    logic                 dzero_q, dzero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 w_is_r;
    logic                 w_md_op;
    logic                 w_hilo_rd;
    logic                 w_signed;
    logic                 w_sa, w_sb;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo, w_rem;

    // ALU opcode decode; unknown R-type functs fall back to ADD and flag invalid
    always_comb begin
        alucont = 4'b0010;
        invalid = 1'b0;
        case (aluop)
            2'b00: alucont = 4'b0010;
            2'b01: alucont = 4'b0110;
            2'b11: alucont = 4'b0001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alucont = 4'b0010;
                    6'b100010, 6'b100011: alucont = 4'b0110;
                    6'b100100:            alucont = 4'b0000;
                    6'b100101:            alucont = 4'b0001;
                    6'b100110:            alucont = 4'b0011;
                    6'b100111:            alucont = 4'b1100;
                    6'b101010:            alucont = 4'b0111;
                    6'b101011:            alucont = 4'b1111;
                    6'b000000:            alucont = 4'b1000;
                    6'b000010:            alucont = 4'b1001;
                    6'b000011:            alucont = 4'b1010;
                    C_F_MULT, C_F_MULTU, C_F_DIV, C_F_DIVU,
                    C_F_MFHI, C_F_MFLO:   alucont = 4'b0010;
                    default: begin
                        alucont = 4'b0010;
                        invalid = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Hazard detection and operand conditioning for a new mul/div op
    always_comb begin
        w_is_r    = valid && (aluop == 2'b10);
        w_md_op   = w_is_r && ((funct == C_F_MULT) || (funct == C_F_MULTU) ||
                               (funct == C_F_DIV)  || (funct == C_F_DIVU));
        w_hilo_rd = w_is_r && ((funct == C_F_MFHI) || (funct == C_F_MFLO));
        stall     = busy_q && (w_md_op || w_hilo_rd);
        w_signed  = ~funct[0];
        w_sa      = w_signed && srca[WIDTH-1];
        w_sb      = w_signed && srcb[WIDTH-1];
        w_mag_a   = w_sa ? -srca : srca;
        w_mag_b   = w_sb ? -srcb : srcb;
    end

    // One iteration step of shift-add multiply / restoring divide, plus sign fix-up
    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
        w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        w_rem_diff = w_rem_sh - {1'b0, op_q};
        w_prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
        w_quo      = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_rem      = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Sequencer next-state: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_mul_d = is_mul_q;
        dzero_d  = dzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_md_op) begin
                    is_mul_d = ~funct[1];
                    sa_d     = w_sa;
                    sb_d     = w_sb;
                    dzero_d  = (srcb == '0);
                    cnt_d    = '0;
                    if (~funct[1]) begin
                        op_d  = w_mag_a;
                        acc_d = {{WIDTH{1'b0}}, w_mag_b};
                    end else begin
                        op_d  = w_mag_b;
                        acc_d = {{WIDTH{1'b0}}, w_mag_a};
                    end
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (is_mul_q) begin
                    acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
                end else if (w_rem_sh >= {1'b0, op_q}) begin
                    acc_d = {w_rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_mul_q) begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end else begin
                    // A zero divisor leaves the dividend in the remainder half,
                    // so only the quotient needs overriding.
                    hi_d = w_rem;
                    lo_d = dzero_q ? '1 : w_quo;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_mul_q <= 1'b0;
            dzero_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_mul_q <= is_mul_d;
            dzero_q  <= dzero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
`default_nettype wire
